acc_uart_tx: RTL and testbench

- Downstream stage of the host-protocol controller. Accepts one accumulator result word per load handshake and splits it into bytes.
- Transmits each byte on the board's serial TX line as UART 8N1 frames.
- Drives the busy signal the controller polls before advancing its result selector. The result mux sits between them: word_in is the accumulator word the controller's sel currently addresses.

---
 rtl/acc_uart_tx_if.sv | 30 +++
 rtl/acc_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_acc_uart_tx.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_uart_tx_if.sv
// acc_uart_tx_if: word/handshake bundle between the result mux/controller
// and the UART word transmitter; master = controller side, slave = transmitter.
interface acc_uart_tx_if #(
    parameter int unsigned WORD_BYTES = 2
);
    logic [8*WORD_BYTES-1:0] word_in;
    logic                    load;
    logic                    busy;
    logic                    tx;
    logic                    byte_done;
    logic                    word_done;

    modport master (
        output word_in,
        output load,
        input  busy,
        input  tx,
        input  byte_done,
        input  word_done
    );

    modport slave (
        input  word_in,
        input  load,
        output busy,
        output tx,
        output byte_done,
        output word_done
    );
endinterface

// File: rtl/acc_uart_tx.sv
// acc_uart_tx: latches one accumulator word per load and sends its bytes
// MSB-byte first as UART frames. Optional macro ACC_UART_TX_PARITY_EN adds an even-parity bit (8E1).
module acc_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned WORD_BYTES   = 2
) (
    input  logic        clk,
    input  logic        nRst,
    acc_uart_tx_if.slave bus
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned WW = 8 * WORD_BYTES;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [WW-1:0] sreg_q, sreg_d;
    logic          busy_q, busy_d;
    logic          tx_q, tx_d;
    logic          byte_done_q, byte_done_d;
    logic          word_done_q, word_done_d;

    logic [7:0]    cur_byte;
    logic          bit_end;

    // The byte on the wire is always the top byte; the word shifts up per byte.
    assign cur_byte = sreg_q[WW-1 -: 8];
    assign bit_end  = (cnt_q == CNT_MAX);

    // Next-state, counter and output logic for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        byte_idx_d  = byte_idx_q;
        sreg_d      = sreg_q;
        busy_d      = busy_q;
        byte_done_d = 1'b0;
        word_done_d = 1'b0;
        tx_d        = 1'b1;

        unique case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (bus.load && !busy_q) begin
                    sreg_d     = bus.word_in;
                    byte_idx_d = LAST_BYTE;
                    busy_d     = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                tx_d = cur_byte[bit_idx_q];
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef ACC_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef ACC_UART_TX_PARITY_EN
            PARITY: begin
                tx_d = ^cur_byte;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d       = '0;
                    byte_done_d = 1'b1;
                    if (byte_idx_q != 2'd0) begin
                        byte_idx_d = byte_idx_q - 2'd1;
                        sreg_d     = sreg_q << 8;
                        state_d    = START;
                    end else begin
                        word_done_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                cnt_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Register all state and outputs; reset forces the line idle at once.
    always_ff @(posedge clk or posedge nRst) begin
        if (nRst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            byte_idx_q  <= '0;
            sreg_q      <= '0;
            busy_q      <= 1'b0;
            tx_q        <= 1'b1;
            byte_done_q <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            sreg_q      <= sreg_d;
            busy_q      <= busy_d;
            tx_q        <= tx_d;
            byte_done_q <= byte_done_d;
            word_done_q <= word_done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.tx        = tx_q;
    assign bus.byte_done = byte_done_q;
    assign bus.word_done = word_done_q;

endmodule

// File: tb/tb_acc_uart_tx.sv
// tb_acc_uart_tx: directed checks of acc_uart_tx at CLKS_PER_BIT=4, WORD_BYTES=2.
// Optional macro ACC_UART_TX_PARITY_EN enables the parity scenario.
module tb_acc_uart_tx;

    localparam int CPB = 4;
    localparam int WB  = 2;
`ifdef ACC_UART_TX_PARITY_EN
    localparam int FB  = 11;
`else
    localparam int FB  = 10;
`endif

    logic clk  = 1'b0;
    logic nRst = 1'b1;
    always #5 clk = ~clk;

    acc_uart_tx_if #(.WORD_BYTES(WB)) bus ();

    acc_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .WORD_BYTES  (WB)
    ) dut (
        .clk (clk),
        .nRst(nRst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int wd_cnt = 0;
    logic [7:0] rxq[$];
    logic       parq[$];

    // Serial decoder: finds each start bit and samples every bit once.
    initial begin : rx_monitor
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge clk);
            if (nRst == 1'b0 && bus.tx == 1'b0) begin
                for (int j = 0; j < 8; j++) begin
                    repeat (CPB) @(negedge clk);
                    b[j] = bus.tx;
                end
`ifdef ACC_UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                parq.push_back(bus.tx);
`endif
                repeat (CPB) @(negedge clk);
                rxq.push_back(b);
            end
        end
    end

    always @(negedge clk) if (bus.word_done) wd_cnt++;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        ok = !bus.busy;
        for (int i = 0; i < lim && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = !bus.busy;
        end
    endtask

    task automatic test_reset;
        int act;
        bus.load    = 1'b0;
        bus.word_in = '0;
        nRst = 1'b1;
        tick(3);
        nRst = 1'b0;
        tick(1);
        checks++;
        if (bus.tx !== 1'b1) begin
            errors++; $display("FAIL reset_tx: got %b want 1", bus.tx);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        checks++;
        if (bus.byte_done !== 1'b0) begin
            errors++; $display("FAIL reset_byte_done: got %b want 0", bus.byte_done);
        end
        checks++;
        if (bus.word_done !== 1'b0) begin
            errors++; $display("FAIL reset_word_done: got %b want 0", bus.word_done);
        end
        act = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (bus.busy !== 1'b0 || bus.tx !== 1'b1 ||
                bus.byte_done !== 1'b0 || bus.word_done !== 1'b0) act++;
        end
        checks++;
        if (act != 0) begin
            errors++; $display("FAIL reset_quiet: got %0d active cycles want 0", act);
        end
        checks++;
        if (rxq.size() != 0) begin
            errors++; $display("FAIL reset_rx: got %0d bytes want 0", rxq.size());
        end
    endtask

    task automatic test_single_word;
        logic [0:10] fa;
        logic [0:10] fb;
        int pos, bi, exp_tx;
        logic exp_busy, exp_bd, exp_wd;
        bit ok;
        // time-ordered frame bits: start, data LSB first, [parity], stop
`ifdef ACC_UART_TX_PARITY_EN
        fa = 11'b0_10100101_0_1;
        fb = 11'b0_00111100_0_1;
`else
        fa = 11'b0_10100101_1_0;
        fb = 11'b0_00111100_1_0;
`endif
        rxq.delete();
        @(negedge clk);
        bus.word_in = 16'hA53C;
        bus.load    = 1'b1;
        tick(1);
        bus.load = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL single_busy_rise: got %b want 1", bus.busy);
        end
        checks++;
        if (bus.tx !== 1'b1) begin
            errors++; $display("FAIL single_tx_latency: got %b want 1", bus.tx);
        end
        for (int n = 1; n <= 2 * CPB * FB; n++) begin
            tick(1);
            pos = n - 1;
            bi  = (pos % (CPB * FB)) / CPB;
            exp_tx   = (pos < CPB * FB) ? int'(fa[bi]) : int'(fb[bi]);
            exp_busy = (n < 2 * CPB * FB);
            exp_bd   = (n == CPB * FB) || (n == 2 * CPB * FB);
            exp_wd   = (n == 2 * CPB * FB);
            checks++;
            if (bus.tx !== exp_tx[0]) begin
                errors++; $display("FAIL single_tx c%0d: got %b want %0d", n, bus.tx, exp_tx);
            end
            checks++;
            if (bus.busy !== exp_busy) begin
                errors++; $display("FAIL single_busy c%0d: got %b want %b", n, bus.busy, exp_busy);
            end
            checks++;
            if (bus.byte_done !== exp_bd) begin
                errors++; $display("FAIL single_byte_done c%0d: got %b want %b", n, bus.byte_done, exp_bd);
            end
            checks++;
            if (bus.word_done !== exp_wd) begin
                errors++; $display("FAIL single_word_done c%0d: got %b want %b", n, bus.word_done, exp_wd);
            end
        end
        tick(1);
        checks++;
        if (bus.tx !== 1'b1 || bus.byte_done !== 1'b0) begin
            errors++; $display("FAIL single_after: got tx=%b bd=%b want tx=1 bd=0", bus.tx, bus.byte_done);
        end
        wait_idle(10, ok);
        tick(4);
        checks++;
        if (rxq.size() != 2 || rxq[0] !== 8'hA5 || rxq[1] !== 8'h3C) begin
            errors++; $display("FAIL single_rx: got %0d bytes want 2 (A5,3C)", rxq.size());
        end
    endtask

    task automatic test_load_while_busy;
        bit ok;
        rxq.delete();
        @(negedge clk);
        bus.word_in = 16'h5AC3;
        bus.load    = 1'b1;
        tick(1);
        bus.load = 1'b0;
        tick(20);
        @(negedge clk);
        bus.word_in = 16'hFFFF;
        bus.load    = 1'b1;
        tick(1);
        bus.load = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL lwb_busy: got %b want 1", bus.busy);
        end
        wait_idle(2 * CPB * FB + 10, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL lwb_timeout: got busy=%b want 0", bus.busy);
        end
        tick(20);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL lwb_no_requeue: got busy=%b want 0", bus.busy);
        end
        checks++;
        if (rxq.size() != 2) begin
            errors++; $display("FAIL lwb_count: got %0d bytes want 2", rxq.size());
        end else begin
            checks++;
            if (rxq[0] !== 8'h5A || rxq[1] !== 8'hC3) begin
                errors++; $display("FAIL lwb_data: got %h %h want 5a c3", rxq[0], rxq[1]);
            end
        end
    endtask

    task automatic test_streaming;
        int acc, wd0, since, gap_bad, lim;
        logic pb;
        bit ok;
        logic [7:0] expb;
        rxq.delete();
        wd0 = wd_cnt;
        acc = 0;
        gap_bad = 0;
        since = -1;
        pb = bus.busy;
        @(negedge clk);
        bus.word_in = 16'h0000;
        bus.load    = 1'b1;
        lim = 0;
        while (acc < 16 && lim < 3000) begin
            @(negedge clk);
            lim++;
            if (since >= 0) since++;
            if (bus.busy && !pb) begin
                if (acc > 0 && since != 1) gap_bad++;
                acc++;
                bus.word_in = 16'(acc);
                if (acc == 16) bus.load = 1'b0;
            end
            if (bus.word_done) since = 0;
            pb = bus.busy;
        end
        bus.load = 1'b0;
        checks++;
        if (acc != 16) begin
            errors++; $display("FAIL stream_accepts: got %0d want 16", acc);
        end
        wait_idle(2 * CPB * FB + 10, ok);
        tick(6);
        checks++;
        if (wd_cnt - wd0 != 16) begin
            errors++; $display("FAIL stream_word_done: got %0d want 16", wd_cnt - wd0);
        end
        checks++;
        if (gap_bad != 0) begin
            errors++; $display("FAIL stream_gap: got %0d bad gaps want 0", gap_bad);
        end
        checks++;
        if (rxq.size() != 32) begin
            errors++; $display("FAIL stream_count: got %0d bytes want 32", rxq.size());
        end
        for (int i = 0; i < 32 && i < rxq.size(); i++) begin
            expb = (i % 2 == 0) ? 8'h00 : 8'(i / 2);
            checks++;
            if (rxq[i] !== expb) begin
                errors++; $display("FAIL stream_byte%0d: got %h want %h", i, rxq[i], expb);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        rxq.delete();
        @(negedge clk);
        bus.word_in = 16'h5678;
        bus.load    = 1'b1;
        tick(1);
        bus.load = 1'b0;
        tick(18);
        checks++;
        if (bus.tx !== 1'b0) begin
            errors++; $display("FAIL mid_pre_bit3: got %b want 0", bus.tx);
        end
        nRst = 1'b1;
        #1;
        checks++;
        if (bus.tx !== 1'b1) begin
            errors++; $display("FAIL mid_tx: got %b want 1", bus.tx);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL mid_busy: got %b want 0", bus.busy);
        end
        tick(2);
        nRst = 1'b0;
        tick(60);
        rxq.delete();
        @(negedge clk);
        bus.word_in = 16'h1234;
        bus.load    = 1'b1;
        tick(1);
        bus.load = 1'b0;
        wait_idle(2 * CPB * FB + 10, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL mid_timeout: got busy=%b want 0", bus.busy);
        end
        tick(6);
        checks++;
        if (rxq.size() != 2 || rxq[0] !== 8'h12 || rxq[1] !== 8'h34) begin
            errors++; $display("FAIL mid_rx: got %0d bytes want 2 (12,34)", rxq.size());
        end
    endtask

`ifdef ACC_UART_TX_PARITY_EN
    task automatic test_parity;
        int n;
        bit f, ok;
        rxq.delete();
        parq.delete();
        @(negedge clk);
        bus.word_in = 16'h0701;
        bus.load    = 1'b1;
        tick(1);
        bus.load = 1'b0;
        n = 0;
        f = 1'b0;
        while (!f && n < 200) begin
            tick(1);
            n++;
            f = bus.byte_done;
        end
        checks++;
        if (!f || n != 44) begin
            errors++; $display("FAIL parity_frame_len: got %0d cycles want 44", n);
        end
        wait_idle(100, ok);
        tick(8);
        checks++;
        if (parq.size() != 2 || parq[0] !== 1'b1 || parq[1] !== 1'b1) begin
            errors++; $display("FAIL parity_bits: got %0d bits want 2 (1,1)", parq.size());
        end
        checks++;
        if (rxq.size() != 2 || rxq[0] !== 8'h07 || rxq[1] !== 8'h01) begin
            errors++; $display("FAIL parity_rx: got %0d bytes want 2 (07,01)", rxq.size());
        end
    endtask
`endif

    initial begin
        bus.load    = 1'b0;
        bus.word_in = '0;
        test_reset();
        test_single_word();
        test_load_while_busy();
        test_streaming();
        test_reset_mid_frame();
`ifdef ACC_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
